// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared widths, sample typedefs and counter helper for the fir datapath
package fir_pkg;

    localparam int FIR_X_W     = 17;
    localparam int FIR_Y_W     = 36;
    localparam int FIR_Q_W     = 16;
    localparam int FIR_SHIFT_W = 6;

    typedef logic signed [FIR_Y_W-1:0] fir_y_t;
    typedef logic signed [FIR_Q_W-1:0] fir_q_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

endpackage

// File: rtl/fir_out_requant_if.sv
// rtl/fir_out_requant_if.sv - ready/valid output stream of the requantizer
interface fir_out_requant_if #(
    parameter int OUT_W = 16
);
    logic signed [OUT_W-1:0] q_out;
    logic                    q_vld;
    logic                    q_rdy;

    modport master (output q_out, output q_vld, input q_rdy);
    modport slave  (input q_out, input q_vld, output q_rdy);
endinterface

// File: rtl/fir_req_fifo.sv
// rtl/fir_req_fifo.sv - single-clock FIFO, power-of-two depth, extra pointer MSB for full/empty
module fir_req_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];
    logic         wr_en;
    logic         rd_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level = wr_ptr - rd_ptr;
    assign rd_en = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign wr_en = push && (!full || rd_en);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/fir_out_requant.sv
// rtl/fir_out_requant.sv - round/shift/fit fir results to 16 bits and queue them for a ready/valid consumer
// FIR_REQ_SAT_EN: clip to the output range and count clips; otherwise wrap and tie sat_cnt to 0.
module fir_out_requant
    import fir_pkg::*;
#(
    parameter int IN_W    = FIR_Y_W,
    parameter int OUT_W   = FIR_Q_W,
    parameter int SHIFT_W = FIR_SHIFT_W,
    parameter int DEPTH   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [IN_W-1:0]   y_in,
    input  logic                     y_vld,
    input  logic [SHIFT_W-1:0]       shift,
    fir_out_requant_if.master        q,
    output logic [$clog2(DEPTH):0]   fifo_lvl,
    output logic [15:0]              drop_cnt,
    output logic [15:0]              sat_cnt
);
    localparam logic [SHIFT_W-1:0] S_MAX = SHIFT_W'(IN_W - 1);

    logic [SHIFT_W-1:0]      s;
    logic signed [IN_W:0]    ext;
    logic signed [IN_W:0]    add;
    logic signed [IN_W:0]    sum;
    logic signed [IN_W:0]    r1_d;
    logic signed [IN_W:0]    r1;
    logic                    v1;
    logic signed [OUT_W-1:0] q2_d;
    logic signed [OUT_W-1:0] q2;
    logic                    v2;
    logic                    clip;
    logic                    full;
    logic                    empty;
    logic                    pop;
    logic                    push;
    logic                    drop;
    logic [OUT_W-1:0]        fifo_dout;

    // One guard bit above IN_W keeps the rounding addend from overflowing.
    always_comb begin
        s    = (shift > S_MAX) ? S_MAX : shift;
        ext  = {y_in[IN_W-1], y_in};
        add  = '0;
        if (s != '0) begin
            add = (IN_W+1)'(1) << (s - SHIFT_W'(1));
        end
        sum  = ext + add;
        r1_d = sum >>> s;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1 <= 1'b0;
            r1 <= '0;
        end else begin
            v1 <= y_vld;
            if (y_vld) begin
                r1 <= r1_d;
            end
        end
    end

`ifdef FIR_REQ_SAT_EN
    localparam logic signed [IN_W:0] Q_MAX = (IN_W+1)'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [IN_W:0] Q_MIN = ~Q_MAX;

    always_comb begin
        clip = 1'b0;
        q2_d = OUT_W'(r1);
        if (r1 > Q_MAX) begin
            clip = 1'b1;
            q2_d = OUT_W'(Q_MAX);
        end else if (r1 < Q_MIN) begin
            clip = 1'b1;
            q2_d = OUT_W'(Q_MIN);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sat_cnt <= '0;
        end else if (v1 && clip) begin
            sat_cnt <= sat_inc16(sat_cnt);
        end
    end
`else
    assign clip    = 1'b0;
    assign q2_d    = OUT_W'(r1);
    assign sat_cnt = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v2 <= 1'b0;
            q2 <= '0;
        end else begin
            v2 <= v1;
            if (v1) begin
                q2 <= q2_d;
            end
        end
    end

    // No bypass: pop needs q_vld, so an empty FIFO never pops the sample being pushed.
    assign pop  = q.q_vld && q.q_rdy;
    assign push = v2 && (!full || pop);
    assign drop = v2 && full && !pop;

    fir_req_fifo #(
        .DEPTH (DEPTH),
        .W     (OUT_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (q2),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty),
        .level (fifo_lvl)
    );

    assign q.q_out = fifo_dout;
    assign q.q_vld = !empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt <= '0;
        end else if (drop) begin
            drop_cnt <= sat_inc16(drop_cnt);
        end
    end

endmodule

// File: doc/fir_out_requant.md
# fir_out_requant

Downstream stage of the `fir` filter. Takes the filter's full-precision 36-bit signed result stream and produces 16-bit output samples. Each sample is rounded, scaled by a programmable right shift, optionally saturated, and queued in a small FIFO. The FIFO gives the consumer a ready/valid interface. The filter has no backpressure, so samples that arrive while the FIFO is full are dropped and counted.

## Interface
Parameters:
- `IN_W`, 36, input sample width; matches `fir` `y_out`.
- `OUT_W`, 16, output sample width.
- `SHIFT_W`, 6, width of the shift control.
- `DEPTH`, 8, FIFO depth in samples; must be a power of two and ≥2.

Ports (clock and reset first):
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `y_in` input IN_W: signed two's-complement filter output.
- `y_vld` input 1: `y_in` is valid this cycle.
- `shift` input SHIFT_W: right-shift amount; must be quasi-static.
- `q_out` output OUT_W: signed FIFO head sample.
- `q_vld` output 1: FIFO not empty.
- `q_rdy` input 1: consumer accepts `q_out`.
- `fifo_lvl` output $clog2(DEPTH)+1: current FIFO occupancy.
- `drop_cnt` output 16: count of samples dropped because the FIFO was full.
- `sat_cnt` output 16: count of samples that were clipped.

Reset values: `q_out`=0, `q_vld`=0, `fifo_lvl`=0, `drop_cnt`=0, `sat_cnt`=0. The pipeline valid bits are also cleared.

## Operation
- **Stage 1 (round/shift)**, registered when `y_vld`=1:
  - `s` is `shift` clamped to IN_W-1.
  - Compute `r = (y_in + (s>0 ? 1<<(s-1) : 0)) >>> s` at IN_W+1 bits. The extra bit prevents overflow of the round addend.
  - This is round-half-up, toward +inf: -3 with s=1 gives -1; 3 with s=1 gives 2.
- **Stage 2 (range fit)**:
  - Fit `r` to OUT_W per the Configuration section.
  - Register it together with its valid bit.
- **FIFO push**: a stage-2 valid sample is written when the FIFO is not full. Otherwise it is discarded and `drop_cnt` increments.
- **FIFO pop**: occurs when `q_vld && q_rdy`.
- **Simultaneous push and pop when full**: both happen; no drop; level unchanged.
- **Simultaneous push and pop when empty**: push only; there is no bypass path, because the pop requires `q_vld`.
- **Pointers**: read/write pointers wrap modulo DEPTH. Full/empty is decided by the extra pointer MSB.
- **Counters**: `drop_cnt` and `sat_cnt` saturate at 16'hFFFF and do not wrap.
- **Shift changes**: the new `shift` value applies to samples sampled from the next edge onward. No flush is performed.
- **`y_vld`=0**: the stage-1 valid bit clears; the data register holds its value.

## Timing
- **Latency**: a sample with `y_vld` high before edge k is registered in stage 1 at edge k and in stage 2 at edge k+1. It is written to the FIFO at edge k+2.
  - If the FIFO was empty, `q_vld` rises after edge k+2 with `q_out` valid, giving 3 cycles of latency.
- **Throughput**: one sample per clock on both sides.
- `q_out` and `q_vld` are registered outputs with no combinational path from `q_rdy`.
- **Reset mid-operation**: in-flight pipeline samples and FIFO contents are discarded, pointers are zeroed, and outputs go to reset values immediately, asynchronously. The first sample after reset deassertion follows normal latency.

## Configuration
- `FIR_REQ_SAT_EN` defined:
  - Stage 2 clips `r` to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Each clipped sample increments `sat_cnt`.
- `FIR_REQ_SAT_EN` undefined:
  - Stage 2 takes the low OUT_W bits of `r`, so out-of-range values wrap.
  - `sat_cnt` is tied to 0.
  - The port list is identical in both builds.

## Structure
- **Shared package `fir_pkg`**:
  - Width constants `FIR_X_W`=17, `FIR_Y_W`=36, `FIR_Q_W`=16, `FIR_SHIFT_W`=6.
  - A signed typedef for the filter result and one for the quantized sample.
- **Sub-module `fir_req_fifo`**:
  - Synchronous single-clock FIFO with parameters DEPTH and width.
  - Ports: push, pop, data in/out, full, empty, level.
  - The top instantiates it and owns the rounding pipeline and both counters.

## Test plan
- **Pass-through**: reset for 10 cycles, `shift`=0, `q_rdy`=1, inputs 6, 0, -5 → `q_out` shows 6, 0, -5 in order. The first `q_vld` appears 3 cycles after the first `y_vld`.
- **Rounding**: `shift`=1, inputs 3, -3, 4 → 2, -1, 2. `shift`=4, input 100000 → 6250.
- **Saturation**: `shift`=0, inputs 40000 and -40000.
  - With `FIR_REQ_SAT_EN`: 32767, -32768, and `sat_cnt`=2.
  - Without it: -25536, 25536, and `sat_cnt`=0.
- **Full FIFO**: `q_rdy`=0, 10 consecutive valid inputs 1..10 → `fifo_lvl`=8 and `drop_cnt`=2. Then `q_rdy`=1 → 1..8 emerge on consecutive cycles, then `q_vld`=0 and `fifo_lvl`=0.
- **Push/pop at full**: fill to 8, then drive `q_rdy`=1 with a continuous input stream → `fifo_lvl` stays at 8 and `drop_cnt` does not increment.
- **Reset mid-operation**: with 5 samples queued, assert `reset` for one cycle → `q_vld`=0, `fifo_lvl`=0, and both counters are 0. The next input appears 3 cycles later.
